// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris controller and datapath: op codes, controller
// states, player move codes and board geometry.
package tetris_pkg;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 4;

  typedef enum logic [2:0] {
    OP_GEN      = 3'b000,
    OP_MOVE     = 3'b001,
    OP_LAND     = 3'b010,
    OP_CLEAR    = 3'b011,
    OP_NEWBOARD = 3'b100,
    OP_DROP     = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_PLAY,
    ST_DROP,
    ST_LAND,
    ST_CLEAR,
    ST_NEWBOARD,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    MV_LEFT   = 2'd0,
    MV_RIGHT  = 2'd1,
    MV_ROTATE = 2'd2,
    MV_RSVD   = 2'd3
  } move_e;

endpackage

// File: rtl/tetris_ctrl_drop_timer.sv
// Gravity counter: counts enabled cycles and flags the last cycle of each
// PERIOD-long window, wrapping back to zero on that cycle.
module drop_timer #(
  parameter int PERIOD = 16
) (
  input  logic clka,
  input  logic restart_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] TC = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TC);

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tetris_ctrl.sv
// Game sequencer: launches one datapath op at a time, arbitrates player moves
// against gravity, and keeps score and game-over.
//
// state    | meaning
// IDLE     | out of reset, launches the first GEN
// GEN      | spawning a new piece
// PLAY     | piece falling; moves accepted, gravity counting
// DROP     | one-row gravity descent in flight
// LAND     | locking the piece into the board
// CLEAR    | sample row_full, clear the lowest full row
// NEWBOARD | committing the board before the next spawn
// OVER     | game ended; inputs ignored until reset
module tetris_ctrl
  import tetris_pkg::*;
#(
  parameter int DROP_PERIOD = 16,
  parameter int ROWS        = BOARD_ROWS,
  parameter int SCORE_W     = 8
) (
  input  logic                    clka,
  input  logic                    restart_n,
  input  logic                    move_valid,
  input  logic [1:0]              move,
  input  logic                    dp_done,
  input  logic                    dp_error,
  input  logic                    landed,
  input  logic [ROWS-1:0]         row_full,
  output logic                    op_start,
  output logic [2:0]              op,
  output logic [1:0]              op_move,
  output logic [$clog2(ROWS)-1:0] clear_row,
  output logic [2:0]              state,
  output logic [SCORE_W-1:0]      score,
  output logic                    game_over
);

  localparam int RW = $clog2(ROWS);

  state_e        st;
  logic          busy;
  logic          drop_pend;
  logic          tick;
  logic          accept;
  logic          tmr_clr;
  logic [RW-1:0] low_row;

  // A done in the same cycle as its op_start is too early to belong to it.
  assign accept  = busy && !op_start && dp_done;
  assign tmr_clr = (st == ST_GEN) && accept && !dp_error;
  assign state   = st;

  drop_timer #(
    .PERIOD(DROP_PERIOD)
  ) u_drop_timer (
    .clka     (clka),
    .restart_n(restart_n),
    .en       (st == ST_PLAY),
    .clr      (tmr_clr),
    .tick     (tick)
  );

  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row_full[i]) low_row = RW'(i);
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      st        <= ST_IDLE;
      op_start  <= 1'b0;
      op        <= OP_GEN;
      op_move   <= '0;
      clear_row <= '0;
      score     <= '0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      drop_pend <= 1'b0;
    end else begin
      op_start <= 1'b0;
      if (accept) busy <= 1'b0;

      if (accept && dp_error) begin
        st        <= ST_OVER;
        game_over <= 1'b1;
        drop_pend <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            st       <= ST_GEN;
            op       <= OP_GEN;
            op_start <= 1'b1;
            busy     <= 1'b1;
          end
          ST_GEN: begin
            if (accept) st <= ST_PLAY;
          end
          ST_PLAY: begin
            if (busy) begin
              // Gravity that lands during a move is deferred to the move's done.
              if (accept) begin
                if (tick || drop_pend) begin
                  drop_pend <= 1'b0;
                  st        <= ST_DROP;
                  op        <= OP_DROP;
                  op_start  <= 1'b1;
                  busy      <= 1'b1;
                end
              end else if (tick) begin
                drop_pend <= 1'b1;
              end
            end else if (tick) begin
              st       <= ST_DROP;
              op       <= OP_DROP;
              op_start <= 1'b1;
              busy     <= 1'b1;
            end else if (move_valid && (move != MV_RSVD)) begin
              op       <= OP_MOVE;
              op_move  <= move;
              op_start <= 1'b1;
              busy     <= 1'b1;
            end
          end
          ST_DROP: begin
            if (accept) begin
              if (landed) begin
                st       <= ST_LAND;
                op       <= OP_LAND;
                op_start <= 1'b1;
                busy     <= 1'b1;
              end else begin
                st <= ST_PLAY;
              end
            end
          end
          ST_LAND: begin
            if (accept) st <= ST_CLEAR;
          end
          ST_CLEAR: begin
            if (!busy) begin
              if (row_full == '0) begin
                st       <= ST_NEWBOARD;
                op       <= OP_NEWBOARD;
                op_start <= 1'b1;
                busy     <= 1'b1;
              end else begin
                clear_row <= low_row;
                op        <= OP_CLEAR;
                op_start  <= 1'b1;
                busy      <= 1'b1;
              end
            end else if (accept) begin
              if (score != '1) score <= score + 1'b1;
            end
          end
          ST_NEWBOARD: begin
            if (accept) begin
              st       <= ST_GEN;
              op       <= OP_GEN;
              op_start <= 1'b1;
              busy     <= 1'b1;
            end
          end
          ST_OVER: begin
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tetris_ctrl.sv
// Randomized bench for tetris_ctrl: a transaction-level game model predicts every
// op launch, and a monitor checks DUT launches against the predicted queue.
`timescale 1ns/1ps
module tb_tetris_ctrl;

  localparam int P  = 16;
  localparam int NR = 8;

  // op codes as given in the op table
  localparam int C_GEN = 0, C_MOVE = 1, C_LAND = 2, C_CLEAR = 3, C_NEW = 4, C_DROP = 5;
  // model activity
  localparam int W_IDLE = 0, W_PLAY = 1, W_SAMPLE = 2, W_OP = 3, W_OVER = 4;

  logic          clka = 1'b0;
  logic          restart_n = 1'b0;
  logic          move_valid = 1'b0;
  logic [1:0]    move = 2'd0;
  logic          dp_done = 1'b0;
  logic          dp_error = 1'b0;
  logic          landed = 1'b0;
  logic [NR-1:0] row_full = '0;

  logic       op_start, s_op_start;
  logic [2:0] op, s_op;
  logic [1:0] op_move, s_op_move;
  logic [2:0] clear_row, s_clear_row;
  logic [2:0] state, s_state;
  logic [7:0] score;
  logic [1:0] s_score;
  logic       game_over, s_game_over;

  tetris_ctrl #(.DROP_PERIOD(P), .ROWS(NR), .SCORE_W(8)) dut (
    .clka(clka), .restart_n(restart_n), .move_valid(move_valid), .move(move),
    .dp_done(dp_done), .dp_error(dp_error), .landed(landed), .row_full(row_full),
    .op_start(op_start), .op(op), .op_move(op_move), .clear_row(clear_row),
    .state(state), .score(score), .game_over(game_over));

  tetris_ctrl #(.DROP_PERIOD(P), .ROWS(NR), .SCORE_W(2)) dut_sat (
    .clka(clka), .restart_n(restart_n), .move_valid(move_valid), .move(move),
    .dp_done(dp_done), .dp_error(dp_error), .landed(landed), .row_full(row_full),
    .op_start(s_op_start), .op(s_op), .op_move(s_op_move), .clear_row(s_clear_row),
    .state(s_state), .score(s_score), .game_over(s_game_over));

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [1:0] mv;
    logic [2:0] row;
    int         cyc;
    int         score;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // model state
  int m_where, m_op, m_issue, m_pc, m_score, m_done_at;
  bit m_busy, m_pend;
  // stimulus knobs
  int dly_min = 2, dly_max = 2, mv_pct = 0, land_pct = 100, land_mode = 0;
  int err_den = 0, spur_pct = 0;
  bit err_gen = 0, rand_rows = 0;
  int prev_done_op = -1;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int lowest(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_where = W_IDLE; m_busy = 0; m_pc = 0; m_pend = 0; m_score = 0; m_op = -1;
  endtask

  task automatic issue(input int opc, input int mvc, input int row);
    exp_t e;
    e.op = 3'(opc); e.mv = 2'(mvc); e.row = 3'(row); e.cyc = cyc + 1; e.score = m_score;
    exp_q.push_back(e);
    m_busy = 1; m_op = opc; m_issue = cyc + 1;
    m_done_at = m_issue + int'($urandom_range(dly_max, dly_min));
    if (opc != C_MOVE) m_where = W_OP;
  endtask

  // Predicts what the upcoming clock edge does, given this cycle's inputs.
  task automatic model_edge();
    bit busy0, acc, tick;
    if (!restart_n) begin model_reset(); return; end
    if (m_where == W_OVER) return;
    busy0 = m_busy;
    acc = dp_done && busy0 && (cyc > m_issue);
    if (acc) m_busy = 0;
    if (acc && dp_error) begin m_where = W_OVER; return; end
    case (m_where)
      W_IDLE: issue(C_GEN, 0, 0);
      W_PLAY: begin
        tick = (m_pc % P) == P - 1;
        m_pc++;
        if (busy0) begin
          if (tick) m_pend = 1;
          if (acc && m_pend) begin m_pend = 0; issue(C_DROP, 0, 0); end
        end else if (tick) issue(C_DROP, 0, 0);
        else if (move_valid && move != 2'd3) issue(C_MOVE, int'(move), 0);
      end
      W_SAMPLE: begin
        if (row_full == '0) issue(C_NEW, 0, 0);
        else issue(C_CLEAR, 0, lowest(row_full));
      end
      W_OP: begin
        if (acc) begin
          case (m_op)
            C_GEN:   begin m_where = W_PLAY; m_pc = 0; end
            C_DROP:  if (landed) issue(C_LAND, 0, 0); else m_where = W_PLAY;
            C_LAND:  m_where = W_SAMPLE;
            C_CLEAR: begin m_score++; m_where = W_SAMPLE; end
            C_NEW:   issue(C_GEN, 0, 0);
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  endtask

  // Datapath responder and player stimulus for the current cycle.
  task automatic drive();
    if (prev_done_op == C_LAND) begin
      if (land_mode == 1) row_full = 8'b0000_0101;
      else if (land_mode == 2) row_full = 8'($urandom & $urandom & $urandom);
      else row_full = '0;
    end else if (prev_done_op == C_CLEAR) begin
      row_full = row_full & (row_full - 1'b1);
    end
    if (rand_rows) row_full = 8'($urandom);
    prev_done_op = -1;
    dp_done = 0; dp_error = 0; landed = 0;
    if (m_busy && cyc >= m_done_at) begin
      dp_done = 1;
      dp_error = (m_op == C_GEN && err_gen) ||
                 (err_den > 0 && $urandom_range(err_den - 1, 0) == 0);
      landed = (m_op == C_DROP) ? ($urandom_range(99, 0) < land_pct) : 1'($urandom_range(1, 0));
      prev_done_op = m_op;
    end else if ((!m_busy || cyc == m_issue) && $urandom_range(99, 0) < spur_pct) begin
      dp_done = 1;
      dp_error = 1'($urandom_range(1, 0));
      landed = 1'($urandom_range(1, 0));
    end
    move_valid = ($urandom_range(99, 0) < mv_pct);
    move = 2'($urandom_range(3, 0));
  endtask

  task automatic cycle();
    drive();
    model_edge();
    @(posedge clka);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_op_start", op_start, 0);
    chk("rst_op", op, 0);
    chk("rst_op_move", op_move, 0);
    chk("rst_clear_row", clear_row, 0);
    chk("rst_state", state, tetris_pkg::ST_IDLE);
    chk("rst_score", score, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_sat_score", s_score, 0);
    chk("rst_sat_state", s_state, tetris_pkg::ST_IDLE);
  endtask

  // Monitor: every DUT launch must match the head of the expectation queue.
  always @(negedge clka) begin
    if (op_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_op_start: got op %0d expected no launch (cycle %0d)", op, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("launch_cycle", cyc, mon_e.cyc);
        chk("launch_op", op, mon_e.op);
        if (mon_e.op == 3'(C_MOVE)) chk("launch_op_move", op_move, mon_e.mv);
        if (mon_e.op == 3'(C_CLEAR)) chk("launch_clear_row", clear_row, mon_e.row);
        chk("launch_score", score, sat(mon_e.score, 255));
        chk("sat_op_start", s_op_start, 1);
        chk("sat_op", s_op, mon_e.op);
        if (mon_e.op == 3'(C_MOVE)) chk("sat_op_move", s_op_move, mon_e.mv);
        if (mon_e.op == 3'(C_CLEAR)) chk("sat_clear_row", s_clear_row, mon_e.row);
        chk("sat_score", s_score, sat(mon_e.score, 3));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_op_start: got none expected op %0d at cycle %0d", mon_e.op, mon_e.cyc);
    end
  end

  initial begin
    int n;
    model_reset();
    @(posedge clka);
    #1;
    restart_n = 0;
    repeat (2) cycle();
    check_reset_values();

    // Basic game flow: fixed 2-cycle datapath, always landing, no full rows.
    restart_n = 1;
    repeat (80) cycle();
    chk("flow_score", score, sat(m_score, 255));

    // Player moves against gravity with variable op latency and spurious dones.
    dly_min = 1; dly_max = 3; mv_pct = 60; land_pct = 30; spur_pct = 10;
    repeat (400) cycle();
    chk("moves_score", score, sat(m_score, 255));

    // Row clearing: two full rows after each landing.
    restart_n = 0; cycle(); restart_n = 1;
    dly_min = 2; dly_max = 2; mv_pct = 0; land_pct = 100; land_mode = 1; spur_pct = 0;
    n = 0;
    while (m_op != C_NEW && n < 200) begin cycle(); n++; end
    chk("clear_reached_newboard", (m_op == C_NEW), 1);
    chk("clear_score_two", score, 2);
    chk("clear_sat_score_two", s_score, 2);
    n = 0;
    while (m_score < 4 && n < 400) begin cycle(); n++; end
    chk("clear_score_four", score, 4);
    chk("sat_score_holds", s_score, 3);

    // Spawn failure ends the game; nothing launches afterwards.
    restart_n = 0; cycle(); restart_n = 1;
    land_mode = 0; err_gen = 1;
    n = 0;
    while (m_where != W_OVER && n < 50) begin cycle(); n++; end
    chk("over_game_over", game_over, 1);
    chk("over_state", state, tetris_pkg::ST_OVER);
    chk("over_sat_game_over", s_game_over, 1);
    chk("over_sat_state", s_state, tetris_pkg::ST_OVER);
    err_gen = 0; mv_pct = 50; spur_pct = 50; rand_rows = 1;
    repeat (100) cycle();
    chk("over_sticky", game_over, 1);
    rand_rows = 0; row_full = '0;
    restart_n = 0; cycle();
    check_reset_values();
    restart_n = 1;

    // Random soak with occasional resets, including mid-op.
    dly_min = 1; dly_max = 3; mv_pct = 50; land_pct = 50; land_mode = 2;
    err_den = 200; spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      restart_n = !(m_where == W_OVER || $urandom_range(399, 0) == 0);
      cycle();
    end
    restart_n = 1;
    chk("soak_score", score, sat(m_score, 255));
    chk("soak_sat_score", s_score, sat(m_score, 3));
    chk("soak_game_over", game_over, (m_where == W_OVER));

    restart_n = 0;
    repeat (2) cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
